// File: rtl/mem_dump_reader.sv
// Memory dump reader: walks a data memory from address 0 and shows addr/data on four hex digits.
// Build option MEM_DUMP_AUTO_SCAN_EN: entries advance after HOLD_TICKS ticks instead of on step.
module mem_dump_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              abort,
  input  logic              tick,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        in3,
  output logic [3:0]        in2,
  output logic [3:0]        in1,
  output logic [3:0]        in0,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start, digits blank
  // REQ   | one-cycle read strobe at the current address
  // WAIT  | read data returns and is captured
  // SHOW  | address and data on the digits until advance
  // FIN   | done pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHOW,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam int                AEXT_W    = (ADDR_W > 8) ? ADDR_W : 8;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              advance;
  logic [AEXT_W-1:0] addr_ext;

`ifdef MEM_DUMP_AUTO_SCAN_EN
  localparam int                HOLD_W    = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              unused_step;

  assign unused_step = step;
  assign advance     = tick && (hold_q == HOLD_LAST);

  // Counts ticks seen in SHOW; saturates so a long hold can never wrap.
  always_comb begin
    hold_d = hold_q;
    if (state_q == S_WAIT) begin
      hold_d = '0;
    end else if ((state_q == S_SHOW) && tick && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_auto;

  assign unused_auto = tick ^ (HOLD_TICKS == 0);
  assign advance     = step;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          addr_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          data_d  = mem_rdata;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        // abort has priority over any advance in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (advance) begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_FIN;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_addr = addr_q;
  assign addr_ext = AEXT_W'(addr_q);

  // Digits are decoded from registered state so they clear as soon as reset asserts.
  always_comb begin
    mem_re = (state_q == S_REQ);
    busy   = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_SHOW);
    done   = (state_q == S_FIN);
    in3    = '0;
    in2    = '0;
    in1    = '0;
    in0    = '0;
    if (state_q == S_SHOW) begin
      in2 = addr_ext[7:4];
      in1 = addr_ext[3:0];
      in0 = 4'(data_q);
    end
  end

endmodule
